// File: rtl/cba_row_streamer_if.sv
// Row-stream link between the tableau streamer (master) and the conjugation unit (slave).
interface cba_row_streamer_if #(
   parameter int unsigned num_qubit = 4
);

   logic                   start;
   logic                   valid_in;
   logic [1:0]             gate_type;
   logic [31:0]            qubit_pos;
   logic [31:0]            qubit_pos2;
   logic [2*num_qubit-1:0] literal_out;
   logic                   phase_out;
   logic                   valid_out;
   logic [2*num_qubit-1:0] literal_in;
   logic                   phase_in;

   modport master (
      output start, valid_in, gate_type, qubit_pos, qubit_pos2, literal_out, phase_out,
      input  valid_out, literal_in, phase_in
   );

   modport slave (
      input  start, valid_in, gate_type, qubit_pos, qubit_pos2, literal_out, phase_out,
      output valid_out, literal_in, phase_in
   );

endinterface

// File: rtl/cba_row_streamer.sv
// Stabilizer tableau holder: streams every row to the conjugation unit for each queued
// Clifford gate, then writes the returned rows back in place.
module cba_row_streamer #(
   parameter int unsigned num_qubit = 4,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   gate_valid,
   output logic                   gate_ready,
   input  logic [1:0]             gate_type_in,
   input  logic [31:0]            qubit_pos_in,
   input  logic [31:0]            qubit_pos2_in,
   input  logic                   tab_wr_en,
   input  logic [31:0]            tab_wr_row,
   input  logic [2*num_qubit-1:0] tab_wr_literal,
   input  logic                   tab_wr_phase,
   input  logic [31:0]            tab_rd_row,
   output logic [2*num_qubit-1:0] tab_rd_literal,
   output logic                   tab_rd_phase,
   cba_row_streamer_if.master     unit,
   output logic                   busy,
   output logic                   done,
   output logic                   err_illegal,
   output logic                   err_timeout
);

   localparam int unsigned LW = 2 * num_qubit;
   localparam int unsigned RW = (num_qubit > 1) ? $clog2(num_qubit) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [RW-1:0] LastRow  = RW'(num_qubit - 1);
   localparam logic [TW-1:0] LastTick = TW'(TIMEOUT - 1);

   localparam logic [2:0] StInit    = 3'd0;
   localparam logic [2:0] StReady   = 3'd1;
   localparam logic [2:0] StSend    = 3'd2;
   localparam logic [2:0] StGap     = 3'd3;
   localparam logic [2:0] StCollect = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [RW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          start_q, start_d;
   logic          done_q, done_d;
   logic          illegal_q, illegal_d;
   logic          timeout_q, timeout_d;
   logic [1:0]    gtype_q, gtype_d;
   logic [31:0]   pos_q, pos_d;
   logic [31:0]   pos2_q, pos2_d;

   logic [LW-1:0] lit_q [num_qubit];
   logic          ph_q  [num_qubit];

   logic          host_wr_ok;
   logic          wr_en;
   logic [RW-1:0] wr_row;
   logic [LW-1:0] wr_lit;
   logic          wr_ph;

   assign host_wr_ok = ((state_q == StInit) || (state_q == StReady)) && tab_wr_en &&
                       (tab_wr_row < num_qubit);

   // Next-state, counters, gate latch and the single tableau write port.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tick_d    = tick_q;
      start_d   = 1'b0;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      timeout_d = timeout_q;
      gtype_d   = gtype_q;
      pos_d     = pos_q;
      pos2_d    = pos2_q;
      wr_en     = host_wr_ok;
      wr_row    = tab_wr_row[RW-1:0];
      wr_lit    = tab_wr_literal;
      wr_ph     = tab_wr_phase;
      case (state_q)
         StInit: begin
            // The unit reloads itself after each gate, so start is needed once per reset.
            start_d = 1'b1;
            state_d = StReady;
         end
         StReady: begin
            if (gate_valid) begin
               if (gate_type_in == 2'd3) begin
                  illegal_d = 1'b1;
               end else begin
                  gtype_d = gate_type_in;
                  pos_d   = qubit_pos_in;
                  pos2_d  = qubit_pos2_in;
                  cnt_d   = '0;
                  state_d = StSend;
               end
            end
         end
         StSend: begin
            if (cnt_q == LastRow) begin
               cnt_d   = '0;
               state_d = StGap;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGap: begin
            // valid_in is low here so the unit does not latch a spurious extra row.
            cnt_d   = '0;
            tick_d  = '0;
            state_d = StCollect;
         end
         StCollect: begin
            if (unit.valid_out) begin
               wr_en  = 1'b1;
               wr_row = cnt_q;
               wr_lit = unit.literal_in;
               wr_ph  = unit.phase_in;
               if (cnt_q == LastRow) begin
                  done_d  = 1'b1;
                  state_d = StReady;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            // A final row arriving on the last tick still completes normally.
            if (state_d == StCollect) begin
               if (tick_q == LastTick) begin
                  timeout_d = 1'b1;
                  state_d   = StReady;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         default: state_d = StInit;
      endcase
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StInit;
         cnt_q     <= '0;
         tick_q    <= '0;
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         gtype_q   <= '0;
         pos_q     <= '0;
         pos2_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         start_q   <= start_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
         gtype_q   <= gtype_d;
         pos_q     <= pos_d;
         pos2_q    <= pos2_d;
      end
   end

   // Tableau storage, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(num_qubit); i++) begin
            lit_q[i] <= '0;
            ph_q[i]  <= 1'b0;
         end
      end else if (wr_en) begin
         lit_q[wr_row] <= wr_lit;
         ph_q[wr_row]  <= wr_ph;
      end
   end

   // Host read port; out-of-range rows read as zero.
   always_comb begin
      tab_rd_literal = '0;
      tab_rd_phase   = 1'b0;
      if (tab_rd_row < num_qubit) begin
         tab_rd_literal = lit_q[tab_rd_row[RW-1:0]];
         tab_rd_phase   = ph_q[tab_rd_row[RW-1:0]];
      end
   end

   assign gate_ready       = (state_q == StReady);
   assign busy             = (state_q == StSend) || (state_q == StGap) || (state_q == StCollect);
   assign done             = done_q;
   assign err_illegal      = illegal_q;
   assign err_timeout      = timeout_q;

   assign unit.start       = start_q;
   assign unit.valid_in    = (state_q == StSend);
   assign unit.gate_type   = gtype_q;
   assign unit.qubit_pos   = pos_q;
   assign unit.qubit_pos2  = pos2_q;
   assign unit.literal_out = (state_q == StSend) ? lit_q[cnt_q] : '0;
   assign unit.phase_out   = (state_q == StSend) ? ph_q[cnt_q] : 1'b0;

endmodule

// File: doc/cba_row_streamer.md
Name: cba_row_streamer

Overview:
- Transmit/collect end of the conjugation control unit's row-stream interface.
- Holds the stabilizer tableau: num_qubit rows, each with 2*num_qubit literal bits (x|z) and 1 phase bit.
- For each queued Clifford gate, presents the gate fields, streams every row into the conjugation unit, then captures the returned rows and writes them back in place, ready for the next gate.

Parameters:
- num_qubit, 4: tableau rows and qubits; literal width is 2*num_qubit.
- TIMEOUT, 64: maximum cycles in COLLECT before err_timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- gate_valid  in  1  gate request present
- gate_ready  out  1  streamer can accept a gate
- gate_type_in  in  2  0 Hadamard, 1 Phase, 2 CNOT, 3 illegal
- qubit_pos_in  in  32  target qubit (H/P) or control qubit (CNOT)
- qubit_pos2_in  in  32  CNOT target qubit
- tab_wr_en  in  1  host tableau row write
- tab_wr_row  in  32  row index for host write
- tab_wr_literal  in  2*num_qubit  literal data for host write
- tab_wr_phase  in  1  phase data for host write
- tab_rd_row  in  32  row index for host read
- tab_rd_literal  out  2*num_qubit  combinational read of the addressed row
- tab_rd_phase  out  1  combinational read of the addressed row
- start  out  1  one-cycle start pulse to the conjugation unit
- valid_in  out  1  row valid to the conjugation unit
- gate_type  out  2  registered gate type
- qubit_pos  out  32  registered first qubit position
- qubit_pos2  out  32  registered second qubit position
- literal_out  out  2*num_qubit  row literal sent to the unit
- phase_out  out  1  row phase sent to the unit
- valid_out  in  1  returned row valid from the unit
- literal_in  in  2*num_qubit  returned row literal
- phase_in  in  1  returned row phase
- busy  out  1  high in any state other than IDLE or READY
- done  out  1  one-cycle pulse when write-back of a gate completes
- err_illegal  out  1  one-cycle pulse when a gate_type 3 request is dropped
- err_timeout  out  1  sticky flag; cleared only by rst

Behaviour:
- Reset values: all outputs 0; gate_type, qubit_pos and qubit_pos2 = 0; tableau contents = 0; state = INIT.
- INIT (1 cycle): assert start = 1, then go to READY.
  - start is issued once per reset only, because the unit returns to its load state after each gate.
- READY:
  - gate_ready = 1; host writes are accepted.
  - On gate_valid with type 0-2: latch the three gate fields, clear the row counter, go to SEND.
  - On gate_valid with type 3: drop the request, pulse err_illegal, stay in READY.
- SEND (exactly num_qubit cycles):
  - valid_in = 1; literal_out and phase_out carry row k, k = 0..num_qubit-1 in ascending order.
  - Rows are driven back-to-back with no bubbles.
- GAP (1 cycle): valid_in = 0. The unit evaluates its row count here; a valid row in this cycle would be loaded as a spurious extra row, so valid_in must be 0.
- COLLECT:
  - Each valid_out cycle writes literal_in and phase_in into row k, k ascending from 0.
  - Returned rows arrive contiguously, num_qubit in total.
  - After the last row is written: pulse done, go to READY.
  - Rows not yet returned keep their old values.
- Gate field hold:
  - gate_type, qubit_pos and qubit_pos2 stay stable from the SEND entry cycle until the cycle after the last returned row.
  - They change only on acceptance in READY.
- Timeout:
  - A cycle counter runs from COLLECT entry.
  - If it reaches TIMEOUT before all rows return: set err_timeout, go to READY, keep any partially written rows.
- Host writes:
  - tab_wr_en is honoured only in READY and INIT; ignored while busy = 1.
  - Out-of-range row indices (>= num_qubit) are ignored on write and read as 0.
- Simultaneous gate_valid and tab_wr_en in READY: the write occurs and the gate is accepted in the same cycle; SEND transmits the newly written row.
- A stray valid_out outside COLLECT is ignored.
- Reset mid-operation: returns to INIT, clears the tableau and reissues start.
- Latency from gate acceptance to done = num_qubit (SEND) + 1 (GAP) + unit processing + num_qubit (returned rows).

Test Plan:
- Reset, then idle → start high exactly 1 cycle after rst falls; busy = 0, gate_ready = 1, all tableau reads 0.
- num_qubit = 4; write identity tableau (row i: z bit i set, x = 0); issue H on qubit 1 with a loopback model of the unit → valid_in high for 4 cycles, low in the GAP cycle; after return, row 1 reads x1 = 1, z1 = 0; done pulses once.
- CNOT control 0, target 2 → qubit_pos = 0 and qubit_pos2 = 2 held stable throughout SEND and COLLECT; the model's returned rows are written to rows 0-3 in order.
- gate_type_in = 3 → err_illegal single pulse, no valid_in activity, state stays READY.
- Unit model never asserts valid_out → err_timeout set after 64 COLLECT cycles, gate_ready = 1 again, tableau unchanged.
- Assert rst in the middle of SEND → outputs return to 0 immediately, tableau cleared, start reissued after release; tab_wr_en asserted while busy has no effect.
